// File: rtl/monitor_bus_frontend.sv
// monitor_bus_frontend: synchronizes the async monitor slot bus, qualifies clk_rw strobes and queues decoded cycles in a show-ahead FIFO
module monitor_bus_frontend #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_HIGH     = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_TIMEOUT = 2000
) (
    input  logic                          clk_20mhz,
    input  logic                          reset,
    input  logic                          clk_rw,
    input  logic                          ax_d,
    input  logic                          r_wx,
    input  logic                          slot_x_int_x,
    input  logic                          reset_x,
    input  logic [7:0]                    data_in,
    output logic                          cyc_valid,
    input  logic                          cyc_ready,
    output logic [7:0]                    cyc_data,
    output logic                          cyc_ax_d,
    output logic                          cyc_r_wx,
    output logic                          cyc_slot_x,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          bus_reset,
    output logic                          overflow,
    output logic [7:0]                    glitch_cnt,
    output logic                          idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MIN_HIGH + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] MH = CW'(MIN_HIGH);
    localparam logic [IW-1:0] IT = IW'(IDLE_TIMEOUT);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    // bit 13 is a constant-1 "live" marker telling real samples from reset fill
    localparam logic [13:0] SYNC_RST = 14'b0_0_0_0_1_1_0000_0000;
    typedef enum logic [1:0] {S_ARM, S_LOW, S_COUNT, S_DONE} state_t;
    state_t state, state_nxt;
    logic [13:0] sync_q [SYNC_STAGES];
    logic [13:0] s;
    logic [10:0] mem [FIFO_DEPTH];
    logic [10:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idle_cnt;
    logic push, glitch, pop, accept, clr, br_nxt;
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {1'b1, clk_rw, ax_d, r_wx, slot_x_int_x, reset_x, data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign s      = sync_q[SYNC_STAGES-1];
    assign br_nxt = !s[8];
    assign clr    = br_nxt | bus_reset;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push      = 1'b0;
        glitch    = 1'b0;
        case (state)
            S_ARM:   state_nxt = (s[13] && !s[12]) ? S_LOW : S_ARM;
            S_LOW: begin
                if (s[12]) begin
                    cnt_nxt   = CW'(1);
                    push      = (MH == CW'(1));
                    state_nxt = push ? S_DONE : S_COUNT;
                end
            end
            S_COUNT: begin
                if (!s[12]) begin
                    glitch    = 1'b1;
                    state_nxt = S_LOW;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    push      = (cnt_nxt == MH);
                    state_nxt = push ? S_DONE : S_COUNT;
                end
            end
            S_DONE:  state_nxt = s[12] ? S_DONE : S_LOW;
            default: state_nxt = S_ARM;
        endcase
        if (clr) begin
            state_nxt = S_LOW;
            push      = 1'b0;
            glitch    = 1'b0;
        end
    end
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            state <= S_ARM;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    assign cyc_valid = (fill != '0);
    assign pop       = cyc_valid & cyc_ready;
    assign accept    = push & ((fill != FULL) | pop);
    always_ff @(posedge clk_20mhz) begin
        if (accept) mem[wr_ptr] <= {s[11], s[10], s[9], s[7:0]};
    end
    always_ff @(posedge clk_20mhz) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (AW+1)'(accept) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            bus_reset  <= 1'b0;
            overflow   <= 1'b0;
            glitch_cnt <= '0;
            idle_cnt   <= '0;
        end else begin
            bus_reset  <= br_nxt;
            overflow   <= !clr && (overflow || (push && !accept));
            glitch_cnt <= clr ? 8'h00 : glitch_cnt + 8'(glitch && glitch_cnt != 8'hFF);
            idle_cnt   <= push ? '0 : idle_cnt + IW'(idle_cnt != IT);
        end
    end
    assign idle = (idle_cnt == IT);
    assign head = mem[rd_ptr];
    assign {cyc_ax_d, cyc_r_wx, cyc_slot_x, cyc_data} = cyc_valid ? head : 11'h000;
endmodule
